alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Registered integer ALU for the datapath execute stage.
//  - Decodes a 6-bit MIPS-style function code; operates on two signed operands.
//  - Captures result and status flags on the rising clock edge, one-cycle latency.
//  - Consumer: writeback/forwarding logic.
// PARAMETERS
//  NB_DATA  8  operand/result width in bits (>=4)
//  NB_OP    6  function-code width
// PORTS
//  i_clk       in   1        clock, rising-edge active
//  i_rst_n     in   1        reset, asynchronous, active-low
//  i_valid     in   1        operands/op valid this cycle
//  i_data_a    in   NB_DATA  operand A, signed two's complement
//  i_data_b    in   NB_DATA  operand B, signed two's complement
//  i_op        in   NB_OP    function code
//  o_result    out  NB_DATA  registered result, signed
//  o_valid     out  1        o_result/flags updated by last edge
//  o_zero      out  1        o_result == 0
//  o_carry     out  1        carry/borrow/shifted-out bit
//  o_overflow  out  1        signed overflow (ADD/SUB only)
//  o_illegal   out  1        i_op was not a supported code
// BEHAVIOUR
//  Interface: one clock i_clk; reset i_rst_n is asynchronous, active-low.
//  Reset: o_result=0, o_valid=0, o_zero=0, o_carry=0, o_overflow=0, o_illegal=0.
//  Timing:
//  - Combinational compute of op(i_data_a, i_data_b).
//  - Edge with i_valid=1: capture into outputs; o_valid=1 the following cycle.
//  - Edge with i_valid=0: o_valid=0; o_result and flags hold previous values.
//  Reset mid-operation: the pending result is discarded.
//  Function codes (6-bit):
//  - 100000 ADD: a+b. carry = unsigned carry-out.
//    Overflow when both operands share a sign and the result sign differs.
//  - 100010 SUB: a-b. carry = borrow (unsigned a<b).
//    Overflow when the operand signs differ and the result sign differs from a.
//  - 100100 AND, 100101 OR, 100110 XOR: bitwise a op b.
//  - 100111 NOR: ~(a|b).
//  - 000011 SRA: a>>>1, sign replicated into MSB; i_data_b ignored; carry=a[0].
//  - 000010 SRL: a>>1, zero into MSB; i_data_b ignored; carry=a[0].
//  - 000000 SLL: a<<1, zero into LSB; carry=a[NB_DATA-1].
//  - Any other code: result 0, o_illegal=1, o_zero=1.
//  Flag rules:
//  - Result truncated to NB_DATA bits (wrap-around, no saturation).
//  - carry=0 and overflow=0 for logic ops.
//  - overflow=0 for all non-ADD/SUB ops.
//  - o_illegal=0 for every supported code.
// CONFIGURATION
//  ALU_VAR_SHIFT_EN defined: adds variable shifts by amount s = i_data_b[$clog2(NB_DATA)-1:0]:
//  - 000100 SLLV, 000110 SRLV, 000111 SRAV.
//  - s=0 passes a through with carry=0.
//  - Otherwise carry = last bit shifted out.
//  ALU_VAR_SHIFT_EN undefined: those codes are illegal (result 0, o_illegal=1).
//  Fixed 1-bit shifts are unaffected either way.
// TESTING  (NB_DATA=8; check one cycle after i_valid edge)
//  - Reset: i_rst_n=0 asynchronously, no clock edge
//    -> immediately o_result=00, o_valid=0, all flags 0.
//  - ADD: a=0A, b=05 -> 0F, carry=0, ovf=0.
//    ADD: a=7F, b=01 -> 80, ovf=1.
//    SUB: a=0C, b=03 -> 09.
//    SUB: a=03, b=0C -> F7, carry=1.
//  - Logic:
//    AND AA&CC -> 88.  OR AA|55 -> FF.  XOR F0^AA -> 5A.
//    NOR F0,0F -> 00, zero=1.
//  - Shifts: a=F0, b=00.
//    SRA -> F8.  SRL -> 78.  SLL -> E0, carry=1.
//  - Illegal/hold:
//    op=111111 -> 00, illegal=1.
//    i_valid=0 next cycle -> o_valid=0, o_result holds.
//  - With ALU_VAR_SHIFT_EN: SRAV a=80, b=03 -> F0.
//    Without ALU_VAR_SHIFT_EN: the same stimulus -> illegal=1.

Source files
------------

// File: rtl/alu.sv
// Registered integer ALU: decodes a MIPS-style function code and captures result and flags with one-cycle latency.
// Optional feature: define ALU_VAR_SHIFT_EN to add the variable shifts SLLV/SRLV/SRAV.
module alu #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_valid,
    output logic               o_zero,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_illegal
);

    localparam logic [NB_OP-1:0] OP_ADD  = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB  = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND  = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR   = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR  = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR  = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA  = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL  = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SLL  = NB_OP'(6'b000000);
`ifdef ALU_VAR_SHIFT_EN
    localparam logic [NB_OP-1:0] OP_SLLV = NB_OP'(6'b000100);
    localparam logic [NB_OP-1:0] OP_SRLV = NB_OP'(6'b000110);
    localparam logic [NB_OP-1:0] OP_SRAV = NB_OP'(6'b000111);
    localparam int               NB_SH   = $clog2(NB_DATA);
`endif

    localparam int MSB = NB_DATA - 1;

    logic [NB_DATA-1:0] w_result;
    logic               w_carry;
    logic               w_overflow;
    logic               w_illegal;
    logic [NB_DATA:0]   w_add;
    logic [NB_DATA:0]   w_sub;

    logic [NB_DATA-1:0] r_result;
    logic               r_valid;
    logic               r_zero;
    logic               r_carry;
    logic               r_overflow;
    logic               r_illegal;

    // Extra top bit holds unsigned carry-out for ADD and borrow for SUB.
    assign w_add = {1'b0, i_data_a} + {1'b0, i_data_b};
    assign w_sub = {1'b0, i_data_a} - {1'b0, i_data_b};

`ifdef ALU_VAR_SHIFT_EN
    logic [NB_SH-1:0] w_shamt;
    logic [NB_DATA:0] w_sllv;
    logic [NB_DATA:0] w_srlv;
    logic [NB_DATA:0] w_srav;

    // One guard bit beyond the operand catches the last bit shifted out; it stays 0 when s=0.
    assign w_shamt = i_data_b[NB_SH-1:0];
    assign w_sllv  = {1'b0, i_data_a} << w_shamt;
    assign w_srlv  = {i_data_a, 1'b0} >> w_shamt;
    assign w_srav  = $unsigned($signed({i_data_a, 1'b0}) >>> w_shamt);
`endif

    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        w_illegal  = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_result   = w_add[NB_DATA-1:0];
                w_carry    = w_add[NB_DATA];
                w_overflow = (i_data_a[MSB] == i_data_b[MSB]) && (w_add[MSB] != i_data_a[MSB]);
            end
            OP_SUB: begin
                w_result   = w_sub[NB_DATA-1:0];
                w_carry    = w_sub[NB_DATA];
                w_overflow = (i_data_a[MSB] != i_data_b[MSB]) && (w_sub[MSB] != i_data_a[MSB]);
            end
            OP_AND: w_result = i_data_a & i_data_b;
            OP_OR:  w_result = i_data_a | i_data_b;
            OP_XOR: w_result = i_data_a ^ i_data_b;
            OP_NOR: w_result = ~(i_data_a | i_data_b);
            OP_SRA: begin
                w_result = {i_data_a[MSB], i_data_a[MSB:1]};
                w_carry  = i_data_a[0];
            end
            OP_SRL: begin
                w_result = {1'b0, i_data_a[MSB:1]};
                w_carry  = i_data_a[0];
            end
            OP_SLL: begin
                w_result = {i_data_a[MSB-1:0], 1'b0};
                w_carry  = i_data_a[MSB];
            end
`ifdef ALU_VAR_SHIFT_EN
            OP_SLLV: {w_carry, w_result} = w_sllv;
            OP_SRLV: {w_result, w_carry} = w_srlv;
            OP_SRAV: {w_result, w_carry} = w_srav;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_result   <= w_result;
                r_zero     <= (w_result == '0);
                r_carry    <= w_carry;
                r_overflow <= w_overflow;
                r_illegal  <= w_illegal;
            end
        end
    end

    assign o_result   = r_result;
    assign o_valid    = r_valid;
    assign o_zero     = r_zero;
    assign o_carry    = r_carry;
    assign o_overflow = r_overflow;
    assign o_illegal  = r_illegal;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (NB_DATA=8): directed literal cases plus randomized traffic against an arithmetic model.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic [7:0] result;
    logic       o_valid, zero, carry, overflow, illegal;

    int n_checks = 0;
    int n_errors = 0;

    alu #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
        .i_data_a(data_a), .i_data_b(data_b), .i_op(op),
        .o_result(result), .o_valid(o_valid), .o_zero(zero),
        .o_carry(carry), .o_overflow(overflow), .o_illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int  res;
        bit  c;
        bit  v;
        bit  ill;
    } exp_t;

    function automatic exp_t model(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ua, ub, sa, sb, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = ub % 8;
        e = '{res: 0, c: 1'b0, v: 1'b0, ill: 1'b0};
        case (f)
            6'b100000: begin
                e.res = (ua + ub) % 256;
                e.c   = (ua + ub) > 255;
                e.v   = (sa + sb > 127) || (sa + sb < -128);
            end
            6'b100010: begin
                e.res = (ua - ub + 256) % 256;
                e.c   = ua < ub;
                e.v   = (sa - sb > 127) || (sa - sb < -128);
            end
            6'b100100: e.res = ua & ub;
            6'b100101: e.res = ua | ub;
            6'b100110: e.res = ua ^ ub;
            6'b100111: e.res = 255 - (ua | ub);
            6'b000011: begin e.res = (sa >>> 1) & 255; e.c = ua[0]; end
            6'b000010: begin e.res = ua / 2;          e.c = ua[0]; end
            6'b000000: begin e.res = (ua * 2) % 256;  e.c = ua >= 128; end
`ifdef ALU_VAR_SHIFT_EN
            6'b000100: begin
                e.res = (ua << s) & 255;
                e.c   = (s != 0) && (((ua >> (8 - s)) & 1) == 1);
            end
            6'b000110: begin
                e.res = ua >> s;
                e.c   = (s != 0) && (((ua >> (s - 1)) & 1) == 1);
            end
            6'b000111: begin
                e.res = (sa >>> s) & 255;
                e.c   = (s != 0) && (((ua >> (s - 1)) & 1) == 1);
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Model state: what the outputs must show after the most recent edge.
    int m_res;
    bit m_valid, m_zero, m_c, m_v, m_ill;
    bit chk_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res = 0; m_valid = 0; m_zero = 0; m_c = 0; m_v = 0; m_ill = 0;
        end else begin
            exp_t e;
            e = model(op, data_a, data_b);
            m_valid = valid;
            if (valid) begin
                m_res = e.res; m_zero = (e.res == 0); m_c = e.c; m_v = e.v; m_ill = e.ill;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("cyc_valid",    int'(o_valid),  int'(m_valid));
            check("cyc_result",   int'(result),   m_res);
            check("cyc_zero",     int'(zero),     int'(m_zero));
            check("cyc_carry",    int'(carry),    int'(m_c));
            check("cyc_overflow", int'(overflow), int'(m_v));
            check("cyc_illegal",  int'(illegal),  int'(m_ill));
        end
    end

    // Called at posedge+2: drive, let one edge capture, return at posedge+2.
    task automatic apply(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
        op = f; data_a = a; data_b = b; valid = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input int r, input bit c, input bit v, input bit z, input bit il);
        check({name, "_valid"}, int'(o_valid), 1);
        check({name, "_res"},   int'(result), r);
        check({name, "_carry"}, int'(carry), int'(c));
        check({name, "_ovf"},   int'(overflow), int'(v));
        check({name, "_zero"},  int'(zero), int'(z));
        check({name, "_ill"},   int'(illegal), int'(il));
    endtask

    logic [5:0] op_pool [14];

    initial begin
        op_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b000011, 6'b000010, 6'b000000, 6'b000100, 6'b000110, 6'b000111,
                    6'b111111, 6'b000001};
        rst_n = 1'b1; valid = 1'b0; op = '0; data_a = '0; data_b = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_result", int'(result), 0);
        check("rst_valid",  int'(o_valid), 0);
        check("rst_flags",  int'({zero, carry, overflow, illegal}), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk_en = 1'b1;

        apply(6'b100000, 8'h0A, 8'h05); expect_out("add1", 8'h0F, 0, 0, 0, 0);
        apply(6'b100000, 8'h7F, 8'h01); expect_out("add_ovf", 8'h80, 0, 1, 0, 0);
        apply(6'b100000, 8'hFF, 8'h01); expect_out("add_carry", 8'h00, 1, 0, 1, 0);
        apply(6'b100010, 8'h0C, 8'h03); expect_out("sub1", 8'h09, 0, 0, 0, 0);
        apply(6'b100010, 8'h03, 8'h0C); expect_out("sub_borrow", 8'hF7, 1, 0, 0, 0);
        apply(6'b100010, 8'h80, 8'h01); expect_out("sub_ovf", 8'h7F, 0, 1, 0, 0);
        apply(6'b100100, 8'hAA, 8'hCC); expect_out("and", 8'h88, 0, 0, 0, 0);
        apply(6'b100101, 8'hAA, 8'h55); expect_out("or", 8'hFF, 0, 0, 0, 0);
        apply(6'b100110, 8'hF0, 8'hAA); expect_out("xor", 8'h5A, 0, 0, 0, 0);
        apply(6'b100111, 8'hF0, 8'h0F); expect_out("nor", 8'h00, 0, 0, 1, 0);
        apply(6'b000011, 8'hF0, 8'h00); expect_out("sra", 8'hF8, 0, 0, 0, 0);
        apply(6'b000010, 8'hF0, 8'h00); expect_out("srl", 8'h78, 0, 0, 0, 0);
        apply(6'b000011, 8'h81, 8'h55); expect_out("sra_c", 8'hC0, 1, 0, 0, 0);
        apply(6'b000000, 8'hF0, 8'h00); expect_out("sll", 8'hE0, 1, 0, 0, 0);
        valid = 1'b0; op = 6'b100000; data_a = 8'h11; data_b = 8'h22;
        @(posedge clk); #2;
        check("hold_valid", int'(o_valid), 0);
        check("hold_result", int'(result), 8'hE0);
        check("hold_carry", int'(carry), 1);
        apply(6'b111111, 8'h12, 8'h34); expect_out("illegal", 8'h00, 0, 0, 1, 1);
`ifdef ALU_VAR_SHIFT_EN
        apply(6'b000111, 8'h80, 8'h03); expect_out("srav", 8'hF0, 0, 0, 0, 0);
        apply(6'b000100, 8'h81, 8'h00); expect_out("sllv0", 8'h81, 0, 0, 0, 0);
        apply(6'b000110, 8'h0C, 8'h03); expect_out("srlv", 8'h01, 1, 0, 0, 0);
`else
        apply(6'b000111, 8'h80, 8'h03); expect_out("srav_ill", 8'h00, 0, 0, 1, 1);
`endif

        // Reset while a capture is pending: outputs clear at once, pending result lost.
        apply(6'b100000, 8'h0A, 8'h05);
        op = 6'b100101; data_a = 8'h33; data_b = 8'h44; valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_result", int'(result), 0);
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_flags", int'({zero, carry, overflow, illegal}), 0);
        @(posedge clk); #2;
        check("midrst_held", int'(result), 0);
        valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            op     = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 13)];
            data_a = 8'($urandom);
            data_b = 8'($urandom);
            valid  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #2;
        end

        valid = 1'b0;
        @(posedge clk); #2;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
